// File: rtl/write_back_commit_pkg.sv
// Shared definitions for the write-back / commit stage: RV32 major opcodes,
// commit record layout, FIFO geometry and opcode decode helpers.
package write_back_commit_pkg;

  // RV32 major opcodes seen in the W stage.
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  // Commit FIFO geometry: four entries, 2-bit pointers, 3-bit occupancy.
  localparam int FIFO_DEPTH = 4;
  typedef logic [1:0] ptr_t;
  typedef logic [2:0] count_t;
  localparam count_t FULL_COUNT = 3'd4;

  // Source of the register-file write data.
  typedef enum logic [1:0] {
    WB_SRC_ALU,
    WB_SRC_MEM,
    WB_SRC_LINK
  } wb_src_e;

  // One retired instruction as seen by the trace/difftest consumer.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] next_pc;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        wen;
  } commit_rec_t;

  // Loads write memory data, jumps write the link address, all else the ALU.
  function automatic wb_src_e wb_src(input logic [6:0] opcode);
    case (opcode)
      LOAD:      return WB_SRC_MEM;
      JAL, JALR: return WB_SRC_LINK;
      default:   return WB_SRC_ALU;
    endcase
  endfunction

  // Opcodes that produce a destination-register result.
  function automatic logic is_writing(input logic [6:0] opcode);
    case (opcode)
      LOAD, JAL, JALR, OP, OP_IMM, LUI, AUIPC: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/write_back_commit_if.sv
// Valid/ready channel carrying the head commit record to the trace consumer.
interface write_back_commit_if;

  logic        commit_valid_o;
  logic        commit_ready_i;
  logic [31:0] commit_pc_o;
  logic [31:0] commit_instr_o;
  logic [31:0] commit_next_pc_o;
  logic [31:0] commit_wdata_o;
  logic [4:0]  commit_rd_o;
  logic        commit_wen_o;

  // Producer side: the write-back stage.
  modport master (
    output commit_valid_o,
    output commit_pc_o,
    output commit_instr_o,
    output commit_next_pc_o,
    output commit_wdata_o,
    output commit_rd_o,
    output commit_wen_o,
    input  commit_ready_i
  );

  // Consumer side: trace / difftest.
  modport slave (
    input  commit_valid_o,
    input  commit_pc_o,
    input  commit_instr_o,
    input  commit_next_pc_o,
    input  commit_wdata_o,
    input  commit_rd_o,
    input  commit_wen_o,
    output commit_ready_i
  );

endinterface

// File: rtl/write_back_commit_fifo.sv
// Four-entry first-word-fall-through FIFO holding commit records.
// A push while full is accepted only when the head is popped in the same cycle.
module commit_fifo
  import write_back_commit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic             full
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  count_t           count;
  logic             do_push;
  logic             do_pop;

  assign valid    = (count != 3'd0);
  assign full     = (count == FULL_COUNT);
  assign do_pop   = pop && valid;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally from 3 to 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately left unreset; its contents are only observed
    // behind valid, and omitting reset keeps it a plain RAM.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/write_back_commit.sv
// Write-back stage: selects register-file write data, gates the write on
// commit/stall, queues a commit record per retired instruction and keeps
// the minstret / mcycle counters.
module write_back_commit
  import write_back_commit_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [6:0]          W_opcode_i,
  input  logic [4:0]          W_rd_i,
  input  logic [31:0]         W_valE_i,
  input  logic [31:0]         W_valM_i,
  input  logic [31:0]         W_default_pc_i,
  input  logic [31:0]         W_instr_i,
  input  logic [31:0]         W_pc_i,
  input  logic [31:0]         W_pre_pc_i,
  input  logic                W_commit_i,
  output logic                rf_wen_o,
  output logic [4:0]          rf_waddr_o,
  output logic [31:0]         rf_wdata_o,
  output logic                wb_stall_req_o,
  output logic [63:0]         minstret_o,
  output logic [63:0]         mcycle_o,
  write_back_commit_if.master commit
);

  logic [31:0] wdata;
  logic        push;
  logic        pop;
  logic        fifo_valid;
  logic        fifo_full;
  commit_rec_t push_rec;
  commit_rec_t head_rec;

  // Write-data select by opcode class.
  always_comb begin
    // NOTE: the default is assigned before the case so no path leaves wdata
    // unassigned, which would otherwise infer a latch.
    wdata = W_valE_i;
    case (wb_src(W_opcode_i))
      WB_SRC_MEM:  wdata = W_valM_i;
      WB_SRC_LINK: wdata = W_default_pc_i;
      default:     wdata = W_valE_i;
    endcase
  end

  // A full FIFO blocks W unless the head drains this very cycle.
  assign pop            = fifo_valid && commit.commit_ready_i;
  assign wb_stall_req_o = fifo_full && !pop;
  assign push           = W_commit_i && !wb_stall_req_o;

  assign rf_wen_o   = push && is_writing(W_opcode_i) && (W_rd_i != 5'd0);
  assign rf_waddr_o = W_rd_i;
  assign rf_wdata_o = wdata;

  assign push_rec = '{
    pc:      W_pc_i,
    instr:   W_instr_i,
    next_pc: W_pre_pc_i,
    wdata:   wdata,
    rd:      W_rd_i,
    wen:     rf_wen_o
  };

  commit_fifo #(
    .WIDTH($bits(commit_rec_t))
  ) u_commit_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head_rec),
    .valid     (fifo_valid),
    .full      (fifo_full)
  );

  // Head record presented on the commit channel.
  assign commit.commit_valid_o   = fifo_valid;
  assign commit.commit_pc_o      = head_rec.pc;
  assign commit.commit_instr_o   = head_rec.instr;
  assign commit.commit_next_pc_o = head_rec.next_pc;
  assign commit.commit_wdata_o   = head_rec.wdata;
  assign commit.commit_rd_o      = head_rec.rd;
  assign commit.commit_wen_o     = head_rec.wen;

  // Retired-instruction and cycle counters, both wrapping modulo 2^64.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcycle_o   <= '0;
      minstret_o <= '0;
    end else begin
      mcycle_o <= mcycle_o + 64'd1;
      if (push) minstret_o <= minstret_o + 64'd1;
    end
  end

endmodule

// File: tb/tb_write_back_commit.sv
// Self-checking bench for write_back_commit: directed scenarios with a
// scoreboard queue of expected commit records compared on every pop.
module tb_write_back_commit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  w_opcode = '0;
  logic [4:0]  w_rd = '0;
  logic [31:0] w_val_e = '0;
  logic [31:0] w_val_m = '0;
  logic [31:0] w_default_pc = '0;
  logic [31:0] w_instr = '0;
  logic [31:0] w_pc = '0;
  logic [31:0] w_pre_pc = '0;
  logic        w_commit = 1'b0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic [63:0] minstret;
  logic [63:0] mcycle;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] next_pc;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        wen;
  } exp_rec_t;

  exp_rec_t    sb[$];
  exp_rec_t    mon_rec;
  logic [63:0] exp_ret = '0;
  logic [63:0] cyc;

  write_back_commit_if cif ();

  write_back_commit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .W_opcode_i     (w_opcode),
    .W_rd_i         (w_rd),
    .W_valE_i       (w_val_e),
    .W_valM_i       (w_val_m),
    .W_default_pc_i (w_default_pc),
    .W_instr_i      (w_instr),
    .W_pc_i         (w_pc),
    .W_pre_pc_i     (w_pre_pc),
    .W_commit_i     (w_commit),
    .rf_wen_o       (rf_wen),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .wb_stall_req_o (wb_stall),
    .minstret_o     (minstret),
    .mcycle_o       (mcycle),
    .commit         (cif)
  );

  always #5 clk = ~clk;

  // Reference cycle count: one per rising edge since reset released.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 64'd1;
  end

  // Scoreboard: every pop handshake must match the oldest expected record.
  always @(negedge clk) begin
    if (!rst && cif.commit_valid_o === 1'b1 && cif.commit_ready_i === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL commit_pop_unexpected got pc=%h with no record expected", cif.commit_pc_o);
      end else begin
        mon_rec = sb.pop_front();
        if (cif.commit_pc_o !== mon_rec.pc || cif.commit_instr_o !== mon_rec.instr ||
            cif.commit_next_pc_o !== mon_rec.next_pc || cif.commit_wdata_o !== mon_rec.wdata ||
            cif.commit_rd_o !== mon_rec.rd || cif.commit_wen_o !== mon_rec.wen) begin
          failures++;
          $display("FAIL commit_record got pc=%h instr=%h npc=%h wdata=%h rd=%0d wen=%0b expected pc=%h instr=%h npc=%h wdata=%h rd=%0d wen=%0b",
                   cif.commit_pc_o, cif.commit_instr_o, cif.commit_next_pc_o, cif.commit_wdata_o,
                   cif.commit_rd_o, cif.commit_wen_o, mon_rec.pc, mon_rec.instr, mon_rec.next_pc,
                   mon_rec.wdata, mon_rec.rd, mon_rec.wen);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic m_writes(input logic [6:0] op);
    case (op)
      7'h03, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h37, 7'h17: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [6:0] op, input logic [31:0] e,
                                          input logic [31:0] m, input logic [31:0] d);
    if (op == 7'h03) return m;
    if (op == 7'h6F || op == 7'h67) return d;
    return e;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one W-stage slot at edge+1, settle to edge+3, compute expectations
  // and queue the expected record when a push is due.
  task automatic issue(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] val_e,
                       input logic [31:0] val_m, input logic [31:0] dpc, input logic [31:0] pc,
                       input logic commit, output logic e_wen, output logic [31:0] e_wdata,
                       output logic e_stall, output logic [63:0] e_ret);
    exp_rec_t r;
    w_opcode     = op;
    w_rd         = rd;
    w_val_e      = val_e;
    w_val_m      = val_m;
    w_default_pc = dpc;
    w_pc         = pc;
    w_pre_pc     = pc + 32'd4;
    w_instr      = {pc[19:8], 5'd2, 3'd0, rd, op};
    w_commit     = commit;
    #2;
    e_ret   = exp_ret;
    e_stall = (sb.size() == 4) && !cif.commit_ready_i;
    e_wdata = m_wdata(op, val_e, val_m, dpc);
    e_wen   = commit && m_writes(op) && (rd != 5'd0) && !e_stall;
    if (commit && !e_stall) begin
      r = '{pc: pc, instr: {pc[19:8], 5'd2, 3'd0, rd, op}, next_pc: pc + 32'd4,
            wdata: e_wdata, rd: rd, wen: e_wen};
      sb.push_back(r);
      exp_ret = exp_ret + 64'd1;
    end
  endtask

  task automatic test_reset();
    cif.commit_ready_i = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks += 4;
    if (cif.commit_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cif.commit_valid_o); end
    if (wb_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", wb_stall); end
    if (minstret !== 64'd0) begin failures++; $display("FAIL reset_minstret got=%0d exp=0", minstret); end
    if (mcycle !== 64'd0) begin failures++; $display("FAIL reset_mcycle got=%0d exp=0", mcycle); end
    @(posedge clk);
    next_cycle();
    rst = 1'b0;
    sb.delete();
    exp_ret = '0;
  endtask

  task automatic test_write_select();
    logic [6:0]  t_op [12] = '{7'h13, 7'h03, 7'h6F, 7'h03, 7'h67, 7'h33,
                               7'h37, 7'h17, 7'h23, 7'h63, 7'h73, 7'h7F};
    logic [4:0]  t_rd [12] = '{5'd5, 5'd0, 5'd1, 5'd7, 5'd2, 5'd31,
                               5'd9, 5'd4, 5'd6, 5'd8, 5'd10, 5'd11};
    logic [31:0] t_e  [12] = '{32'h00000010, 32'h11110000, 32'h22220000, 32'h33330000,
                               32'h44440000, 32'hFFFFFFFF, 32'hABCDE000, 32'h80001000,
                               32'h55550000, 32'h66660000, 32'h77770000, 32'h88880000};
    logic [31:0] t_m  [12] = '{32'h0000AAAA, 32'hDEADBEEF, 32'h0000BBBB, 32'h12345678,
                               32'h0000CCCC, 32'h0000DDDD, 32'h0000EEEE, 32'h0000FFFF,
                               32'h00001111, 32'h00002222, 32'h00003333, 32'h00004444};
    logic [31:0] t_d  [12] = '{32'h00000104, 32'h00000108, 32'h80000008, 32'h00000110,
                               32'h00000100, 32'h00000118, 32'h0000011C, 32'h00000120,
                               32'h00000124, 32'h00000128, 32'h0000012C, 32'h00000130};
    logic ew; logic [31:0] ed; logic es; logic [63:0] er;
    cif.commit_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(t_op[i], t_rd[i], t_e[i], t_m[i], t_d[i], 32'h80000000 + 32'(i * 4), 1'b1, ew, ed, es, er);
      checks += 5;
      if (rf_wen !== ew) begin failures++; $display("FAIL sel_wen[%0d] got=%b exp=%b", i, rf_wen, ew); end
      if (rf_waddr !== t_rd[i]) begin failures++; $display("FAIL sel_waddr[%0d] got=%0d exp=%0d", i, rf_waddr, t_rd[i]); end
      if (rf_wdata !== ed) begin failures++; $display("FAIL sel_wdata[%0d] got=%h exp=%h", i, rf_wdata, ed); end
      if (minstret !== er) begin failures++; $display("FAIL sel_minstret[%0d] got=%0d exp=%0d", i, minstret, er); end
      if (mcycle !== cyc) begin failures++; $display("FAIL sel_mcycle[%0d] got=%0d exp=%0d", i, mcycle, cyc); end
      next_cycle();
    end
  endtask

  task automatic test_bubble();
    logic ew; logic [31:0] ed; logic es; logic [63:0] er;
    logic [6:0] ops [3] = '{7'h33, 7'h03, 7'h6F};
    cif.commit_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 5'd3, 32'h0BAD0000, 32'h0BAD1111, 32'h0BAD2222, 32'h90000000, 1'b0, ew, ed, es, er);
      checks += 3;
      if (rf_wen !== 1'b0) begin failures++; $display("FAIL bubble_wen[%0d] got=%b exp=0", i, rf_wen); end
      if (minstret !== er) begin failures++; $display("FAIL bubble_minstret[%0d] got=%0d exp=%0d", i, minstret, er); end
      if (mcycle !== cyc) begin failures++; $display("FAIL bubble_mcycle[%0d] got=%0d exp=%0d", i, mcycle, cyc); end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    logic ew; logic [31:0] ed; logic es; logic [63:0] er;
    rst = 1'b1;
    sb.delete();
    exp_ret = '0;
    next_cycle();
    rst = 1'b0;
    cif.commit_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(7'h33, 5'(i + 1), 32'hA0000000 + 32'(i), '0, '0, 32'h00001000 + 32'(i * 4), 1'b1, ew, ed, es, er);
      checks += 2;
      if (wb_stall !== es) begin failures++; $display("FAIL fill_stall[%0d] got=%b exp=%b", i, wb_stall, es); end
      if (rf_wen !== ew) begin failures++; $display("FAIL fill_wen[%0d] got=%b exp=%b", i, rf_wen, ew); end
      next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      issue(7'h13, 5'd5, 32'hA0000004, '0, '0, 32'h00001010, 1'b1, ew, ed, es, er);
      checks += 3;
      if (wb_stall !== 1'b1) begin failures++; $display("FAIL held_stall[%0d] got=%b exp=1", i, wb_stall); end
      if (rf_wen !== 1'b0) begin failures++; $display("FAIL held_wen[%0d] got=%b exp=0", i, rf_wen); end
      if (wb_stall !== es) begin failures++; $display("FAIL held_stall_model[%0d] got=%b exp=%b", i, wb_stall, es); end
      next_cycle();
    end
    cif.commit_ready_i = 1'b1;
    issue(7'h13, 5'd5, 32'hA0000004, '0, '0, 32'h00001010, 1'b1, ew, ed, es, er);
    checks += 3;
    if (wb_stall !== 1'b0) begin failures++; $display("FAIL release_stall got=%b exp=0", wb_stall); end
    if (rf_wen !== 1'b1) begin failures++; $display("FAIL release_wen got=%b exp=1", rf_wen); end
    if (rf_wdata !== 32'hA0000004) begin failures++; $display("FAIL release_wdata got=%h exp=a0000004", rf_wdata); end
    next_cycle();
    cif.commit_ready_i = 1'b0;
    issue(7'h33, 5'd1, '0, '0, '0, 32'h0, 1'b0, ew, ed, es, er);
    checks += 2;
    if (minstret !== 64'd5) begin failures++; $display("FAIL stall_minstret got=%0d exp=5", minstret); end
    if (wb_stall !== es) begin failures++; $display("FAIL full_idle_stall got=%b exp=%b", wb_stall, es); end
    next_cycle();
  endtask

  task automatic test_full_push_pop();
    logic ew; logic [31:0] ed; logic es; logic [63:0] er;
    cif.commit_ready_i = 1'b1;
    issue(7'h33, 5'd20, 32'hB0000014, '0, '0, 32'h00001014, 1'b1, ew, ed, es, er);
    checks += 2;
    if (wb_stall !== 1'b0) begin failures++; $display("FAIL pushpop_stall got=%b exp=0", wb_stall); end
    if (rf_wen !== 1'b1) begin failures++; $display("FAIL pushpop_wen got=%b exp=1", rf_wen); end
    next_cycle();
    cif.commit_ready_i = 1'b0;
    issue(7'h6F, 5'd21, '0, '0, 32'h0000101C, 32'h00001018, 1'b1, ew, ed, es, er);
    checks += 2;
    if (wb_stall !== 1'b1) begin failures++; $display("FAIL still_full_stall got=%b exp=1", wb_stall); end
    if (rf_wen !== 1'b0) begin failures++; $display("FAIL still_full_wen got=%b exp=0", rf_wen); end
    next_cycle();
    cif.commit_ready_i = 1'b1;
    issue(7'h6F, 5'd21, '0, '0, 32'h0000101C, 32'h00001018, 1'b1, ew, ed, es, er);
    checks += 2;
    if (rf_wen !== 1'b1) begin failures++; $display("FAIL jal_release_wen got=%b exp=1", rf_wen); end
    if (rf_wdata !== 32'h0000101C) begin failures++; $display("FAIL jal_release_wdata got=%h exp=0000101c", rf_wdata); end
    next_cycle();
    drain();
  endtask

  task automatic drain();
    logic ew; logic [31:0] ed; logic es; logic [63:0] er;
    cif.commit_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(7'h33, 5'd0, '0, '0, '0, '0, 1'b0, ew, ed, es, er);
      if (sb.size() == 0 && cif.commit_valid_o === 1'b0) break;
      next_cycle();
    end
    checks++;
    if (sb.size() != 0 || cif.commit_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty got valid=%b pending=%0d exp valid=0 pending=0", cif.commit_valid_o, sb.size());
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    logic ew; logic [31:0] ed; logic es; logic [63:0] er;
    cif.commit_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(7'h13, 5'(i + 1), 32'hC0000000 + 32'(i), '0, '0, 32'h00002000 + 32'(i * 4), 1'b1, ew, ed, es, er);
      next_cycle();
    end
    issue(7'h33, 5'd0, '0, '0, '0, '0, 1'b0, ew, ed, es, er);
    checks++;
    if (cif.commit_valid_o !== 1'b1) begin failures++; $display("FAIL midrst_queued got=%b exp=1", cif.commit_valid_o); end
    rst = 1'b1;
    #1;
    checks += 4;
    if (cif.commit_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", cif.commit_valid_o); end
    if (wb_stall !== 1'b0) begin failures++; $display("FAIL midrst_stall got=%b exp=0", wb_stall); end
    if (minstret !== 64'd0) begin failures++; $display("FAIL midrst_minstret got=%0d exp=0", minstret); end
    if (mcycle !== 64'd0) begin failures++; $display("FAIL midrst_mcycle got=%0d exp=0", mcycle); end
    sb.delete();
    exp_ret = '0;
    next_cycle();
    rst = 1'b0;
    issue(7'h37, 5'd12, 32'hCAFE0000, '0, '0, 32'h00003000, 1'b1, ew, ed, es, er);
    checks++;
    if (rf_wen !== 1'b1) begin failures++; $display("FAIL post_rst_wen got=%b exp=1", rf_wen); end
    next_cycle();
    issue(7'h33, 5'd0, '0, '0, '0, '0, 1'b0, ew, ed, es, er);
    checks += 4;
    if (cif.commit_valid_o !== 1'b1) begin failures++; $display("FAIL post_rst_valid got=%b exp=1", cif.commit_valid_o); end
    if (cif.commit_pc_o !== 32'h00003000) begin failures++; $display("FAIL post_rst_head_pc got=%h exp=00003000", cif.commit_pc_o); end
    if (cif.commit_wdata_o !== 32'hCAFE0000) begin failures++; $display("FAIL post_rst_head_wdata got=%h exp=cafe0000", cif.commit_wdata_o); end
    if (minstret !== 64'd1) begin failures++; $display("FAIL post_rst_minstret got=%0d exp=1", minstret); end
    next_cycle();
    drain();
  endtask

  initial begin
    test_reset();
    test_write_select();
    test_bubble();
    test_stall();
    test_full_push_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
